// File: rtl/toy_fetch_resp_unit.sv
// Instruction-fetch responder: slot-based request tracker between the ROB icache port and memory.
// Optional same-cycle response-to-ack forwarding is enabled by defining TOY_FETCH_RESP_BYPASS_EN.
module toy_fetch_resp_unit #(
    parameter int SLOT_NUM   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    localparam int TAG_WIDTH = $clog2(SLOT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req_vld,
    output logic                  fetch_req_rdy,
    input  logic [ADDR_WIDTH-1:0] fetch_req_addr,
    input  logic [ID_WIDTH-1:0]   fetch_req_entry_id,
    output logic                  mem_req_vld,
    input  logic                  mem_req_rdy,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [TAG_WIDTH-1:0]  mem_req_tag,
    input  logic                  mem_rsp_vld,
    input  logic [TAG_WIDTH-1:0]  mem_rsp_tag,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  icache_ack_vld,
    input  logic                  icache_ack_rdy,
    output logic [DATA_WIDTH-1:0] icache_ack_pld,
    output logic [ID_WIDTH-1:0]   icache_ack_entry_id,
    input  logic                  fe_ctrl_flush,
    output logic                  busy,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_WAIT = 2'd2,
        SLOT_DONE = 2'd3
    } slot_state_t;

    slot_state_t           state_reg  [SLOT_NUM];
    slot_state_t           state_next [SLOT_NUM];
    logic [ADDR_WIDTH-1:0] addr_reg   [SLOT_NUM];
    logic [ID_WIDTH-1:0]   id_reg     [SLOT_NUM];
    logic [DATA_WIDTH-1:0] data_reg   [SLOT_NUM];
    logic [SLOT_NUM-1:0]   killed_reg;
    logic                  rsp_err_reg;

    logic [SLOT_NUM-1:0] is_free;
    logic [SLOT_NUM-1:0] is_pend;
    logic [SLOT_NUM-1:0] is_wait;
    logic [SLOT_NUM-1:0] is_done;

    genvar gi;
    generate
        for (gi = 0; gi < SLOT_NUM; gi++) begin : g_status
            assign is_free[gi] = (state_reg[gi] == SLOT_FREE);
            assign is_pend[gi] = (state_reg[gi] == SLOT_PEND);
            assign is_wait[gi] = (state_reg[gi] == SLOT_WAIT);
            assign is_done[gi] = (state_reg[gi] == SLOT_DONE);
        end
    endgenerate

    function automatic logic [TAG_WIDTH-1:0] lowest_set(input logic [SLOT_NUM-1:0] vec);
        lowest_set = '0;
        for (int i = SLOT_NUM - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = TAG_WIDTH'(i);
        end
    endfunction

    logic [TAG_WIDTH-1:0] alloc_idx;
    logic [TAG_WIDTH-1:0] issue_idx;
    logic [TAG_WIDTH-1:0] done_idx;
    logic                 any_free;
    logic                 any_pend;
    logic                 any_done;
    logic                 alloc_fire;
    logic                 issue_fire;
    logic                 rsp_hit;
    logic                 done_ack_fire;
    logic                 bypass_fire;

    assign alloc_idx = lowest_set(is_free);
    assign issue_idx = lowest_set(is_pend);
    assign done_idx  = lowest_set(is_done);
    assign any_free  = |is_free;
    assign any_pend  = |is_pend;
    assign any_done  = |is_done;

    // Flush blocks both new allocation and new memory issue in its cycle.
    assign fetch_req_rdy = any_free && !fe_ctrl_flush;
    assign mem_req_vld   = any_pend && !fe_ctrl_flush;
    assign mem_req_addr  = any_pend ? addr_reg[issue_idx] : '0;
    assign mem_req_tag   = any_pend ? issue_idx : '0;

    assign alloc_fire    = fetch_req_vld && fetch_req_rdy;
    assign issue_fire    = mem_req_vld && mem_req_rdy;
    assign rsp_hit       = mem_rsp_vld && is_wait[mem_rsp_tag];
    assign done_ack_fire = any_done && icache_ack_rdy;

`ifdef TOY_FETCH_RESP_BYPASS_EN
    // Forward only when no DONE slot is queued, so acks never overtake parked results.
    assign bypass_fire = rsp_hit && !any_done && icache_ack_rdy;

    always_comb begin
        icache_ack_vld      = any_done || bypass_fire;
        icache_ack_pld      = '0;
        icache_ack_entry_id = '0;
        if (any_done) begin
            icache_ack_pld      = killed_reg[done_idx] ? '0 : data_reg[done_idx];
            icache_ack_entry_id = id_reg[done_idx];
        end else if (bypass_fire) begin
            icache_ack_pld      = mem_rsp_data;
            icache_ack_entry_id = id_reg[mem_rsp_tag];
        end
    end
`else
    assign bypass_fire = 1'b0;

    always_comb begin
        icache_ack_vld      = any_done;
        icache_ack_pld      = '0;
        icache_ack_entry_id = '0;
        if (any_done) begin
            icache_ack_pld      = killed_reg[done_idx] ? '0 : data_reg[done_idx];
            icache_ack_entry_id = id_reg[done_idx];
        end
    end
`endif

    assign busy    = |(~is_free);
    assign rsp_err = rsp_err_reg;

    always_comb begin
        for (int i = 0; i < SLOT_NUM; i++) begin
            state_next[i] = state_reg[i];
            case (state_reg[i])
                SLOT_FREE: begin
                    if (alloc_fire && alloc_idx == TAG_WIDTH'(i)) state_next[i] = SLOT_PEND;
                end
                SLOT_PEND: begin
                    // Flushed requests never reach memory but still owe the ROB an ack.
                    if (fe_ctrl_flush) state_next[i] = SLOT_DONE;
                    else if (issue_fire && issue_idx == TAG_WIDTH'(i)) state_next[i] = SLOT_WAIT;
                end
                SLOT_WAIT: begin
                    if (rsp_hit && mem_rsp_tag == TAG_WIDTH'(i))
                        state_next[i] = bypass_fire ? SLOT_FREE : SLOT_DONE;
                end
                SLOT_DONE: begin
                    if (done_ack_fire && done_idx == TAG_WIDTH'(i)) state_next[i] = SLOT_FREE;
                end
                default: state_next[i] = SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                state_reg[i] <= SLOT_FREE;
                addr_reg[i]  <= '0;
                id_reg[i]    <= '0;
                data_reg[i]  <= '0;
            end
            killed_reg  <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                state_reg[i] <= state_next[i];
                if (alloc_fire && alloc_idx == TAG_WIDTH'(i)) begin
                    addr_reg[i]   <= fetch_req_addr;
                    id_reg[i]     <= fetch_req_entry_id;
                    killed_reg[i] <= 1'b0;
                end
                if (is_pend[i] && fe_ctrl_flush) killed_reg[i] <= 1'b1;
                if (rsp_hit && mem_rsp_tag == TAG_WIDTH'(i)) data_reg[i] <= mem_rsp_data;
            end
            if (mem_rsp_vld && !is_wait[mem_rsp_tag]) rsp_err_reg <= 1'b1;
        end
    end

endmodule
